pipelined_decode: RTL

PIPELINED_DECODE -- requirements
Module: pipelined_decode

---
 rtl/pipelined_decode_pkg.sv | 20 ++
 rtl/pipelined_decode_regfile_bypass.sv | 38 +++
 rtl/pipelined_decode.sv | 99 +++++++++
 3 files changed

// File: rtl/pipelined_decode_pkg.sv
// Shared decode constants: opcodes that select immediate extension, the load
// opcode, and default bit positions inside the control bundle.
package pipelined_decode_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;

  localparam int MEMREAD_BIT_DEF = 0;
  localparam int REGDST_BIT_DEF  = 1;

  // Logical immediates are zero-extended; everything else sign-extends.
  function automatic logic is_zext_op(input logic [5:0] op);
    return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
  endfunction

endpackage

// File: rtl/pipelined_decode_regfile_bypass.sv
// Register file with two combinational read ports, one write port, hardwired
// zero register and same-cycle write-to-read bypass.
module regfile_bypass
  import pipelined_decode_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr1,
  input  logic [AW-1:0]     raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    if (raddr1 != '0) rdata1 = (we && (waddr == raddr1)) ? wdata : regs[raddr1];
    if (raddr2 != '0) rdata2 = (we && (waddr == raddr2)) ? wdata : regs[raddr2];
  end

endmodule

// File: rtl/pipelined_decode.sv
// Decode stage: register read with writeback bypass, immediate extension,
// destination select, load-use bubble insertion and the decode/execute register.
module pipelined_decode
  import pipelined_decode_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int NUM_REGS    = 32,
  parameter int CTRL_W      = 16,
  parameter int MEMREAD_BIT = MEMREAD_BIT_DEF,
  parameter int REGDST_BIT  = REGDST_BIT_DEF,
  localparam int AW         = $clog2(NUM_REGS)
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              InValid,
  output logic              InReady,
  input  logic [31:0]       Instruction,
  input  logic [CTRL_W-1:0] CtrlIn,
  input  logic [AW-1:0]     WriteRegister,
  input  logic [DATA_W-1:0] WriteData,
  input  logic              RegWriteIn,
  input  logic              Move,
  input  logic              Flush,
  input  logic              StallIn,
  output logic              OutValid,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  output logic [DATA_W-1:0] ImmExtended,
  output logic [AW-1:0]     Rs,
  output logic [AW-1:0]     Rt,
  output logic [AW-1:0]     DestReg,
  output logic [CTRL_W-1:0] CtrlOut,
  output logic              HazardStall
);

  logic [5:0]        opcode;
  logic [AW-1:0]     rs_in, rt_in, rd_in, dest_in;
  logic [DATA_W-1:0] rd1, rd2, imm_zext, imm_sext, imm_in;
  logic              hazard;

  assign opcode   = Instruction[31:26];
  assign rs_in    = AW'(Instruction[25:21]);
  assign rt_in    = AW'(Instruction[20:16]);
  assign rd_in    = AW'(Instruction[15:11]);
  assign dest_in  = CtrlIn[REGDST_BIT] ? rd_in : rt_in;
  assign imm_zext = DATA_W'(Instruction[15:0]);
  assign imm_sext = DATA_W'($signed(Instruction[15:0]));
  assign imm_in   = is_zext_op(opcode) ? imm_zext : imm_sext;

  regfile_bypass #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) u_regfile (
    .clk    (Clk),
    .reset  (Reset),
    .we     (RegWriteIn && Move),
    .waddr  (WriteRegister),
    .wdata  (WriteData),
    .raddr1 (rs_in),
    .raddr2 (rt_in),
    .rdata1 (rd1),
    .rdata2 (rd2)
  );

  // A load sitting in the stage cannot forward its data to a dependent consumer.
  assign hazard = OutValid && CtrlOut[MEMREAD_BIT] && (DestReg != '0) &&
                  ((DestReg == rs_in) || (DestReg == rt_in)) && InValid && !Flush;

  assign HazardStall = hazard;
  assign InReady     = Flush || (!StallIn && !hazard);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      OutValid    <= 1'b0;
      CtrlOut     <= '0;
      ReadData1   <= '0;
      ReadData2   <= '0;
      ImmExtended <= '0;
      Rs          <= '0;
      Rt          <= '0;
      DestReg     <= '0;
    end else if (Flush) begin
      OutValid <= 1'b0;
      CtrlOut  <= '0;
    end else if (!StallIn) begin
      if (hazard) begin
        OutValid <= 1'b0;
        CtrlOut  <= '0;
      end else begin
        OutValid    <= InValid;
        CtrlOut     <= InValid ? CtrlIn : '0;
        ReadData1   <= rd1;
        ReadData2   <= rd2;
        ImmExtended <= imm_in;
        Rs          <= rs_in;
        Rt          <= rt_in;
        DestReg     <= dest_in;
      end
    end
  end

endmodule
